// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I core (FETCH/DECODE/EXEC/MEM/WB, HALT, ERR).
// Latency: 4 cycles per instruction (5 for loads/stores) plus memory wait cycles.
// Backpressure: imem_req/dmem_req held until ack; TIMEOUT unacked wait cycles abort to ERR.
// Optional: define EBREAK_HALT_EN so ebreak retires and then parks the FSM in HALT.
module multicycle_ctrl #(
   parameter int TIMEOUT   = 255,
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          inst,
   output logic                 imem_req,
   input  logic                 imem_ack,
   output logic                 dmem_req,
   output logic                 dmem_we,
   input  logic                 dmem_ack,
   input  logic                 is_zero,
   input  logic                 less,
   output logic                 ir_we,
   output logic                 pc_we,
   output logic                 wreg_en,
   output logic [1:0]           pc_sel,
   output logic [2:0]           imm_sel,
   output logic                 alu_asrc,
   output logic [1:0]           alu_bsrc,
   output logic [3:0]           alu_sel,
   output logic [2:0]           state,
   output logic                 halted,
   output logic                 err,
   output logic [INSTRET_W-1:0] instret
);

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                          S_WB    = 3'd4, S_HALT   = 3'd5, S_ERR  = 3'd6;

   localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011,
                          OPC_LOAD   = 7'b0000011, OPC_STORE = 7'b0100011,
                          OPC_BRANCH = 7'b1100011, OPC_JAL   = 7'b1101111,
                          OPC_JALR   = 7'b1100111, OPC_LUI   = 7'b0110111,
                          OPC_AUIPC  = 7'b0010111, OPC_SYSTEM = 7'b1110011;

   // ALU codes follow {funct7[5], funct3}; only the ones chosen explicitly are named
   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000,
                          ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011;

   localparam logic [2:0] IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2,
                          IMM_B    = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

   // Last counter value at which an unacked wait still stays in place
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic [2:0]           state_q, state_d;
   logic [15:0]          wait_q;
   logic                 br_taken_q;
   logic [INSTRET_W-1:0] instret_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       d_legal, d_mem, d_store, d_wreg, d_jal, d_jalr, d_branch, d_asrc;
   logic [1:0] d_bsrc;
   logic [2:0] d_imm;
   logic [3:0] d_alu;
   logic       br_cond, halt_after_wb, waiting, timed_out;
   logic       unused_inst;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign f7b5        = inst[30];
   assign unused_inst = ^inst;

`ifdef EBREAK_HALT_EN
   assign halt_after_wb = (opcode == OPC_SYSTEM) && (funct3 == 3'b000) && inst[20];
   assign halted        = (state_q == S_HALT);
`else
   assign halt_after_wb = 1'b0;
   assign halted        = 1'b0;
`endif

   assign waiting   = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
   assign timed_out = (wait_q == TO_LAST);
   assign state     = state_q;
   assign err       = (state_q == S_ERR);
   assign instret   = instret_q;

   // Instruction classification and operand/ALU selection; inst is stable DECODE..WB
   always_comb begin
      d_legal  = 1'b1;
      d_mem    = 1'b0;
      d_store  = 1'b0;
      d_wreg   = 1'b0;
      d_jal    = 1'b0;
      d_jalr   = 1'b0;
      d_branch = 1'b0;
      d_asrc   = 1'b0;
      d_bsrc   = 2'b00;
      d_imm    = IMM_NONE;
      d_alu    = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            d_wreg = 1'b1;
            d_alu  = {f7b5, funct3};
         end
         OPC_OPIMM: begin
            d_wreg = 1'b1;
            d_imm  = IMM_I;
            d_bsrc = 2'b01;
            // funct7[5] is an immediate bit except for shifts, where it picks SRA
            d_alu  = (funct3[1:0] == 2'b01) ? {f7b5, funct3} : {1'b0, funct3};
         end
         OPC_LOAD: begin
            d_wreg = 1'b1;
            d_mem  = 1'b1;
            d_imm  = IMM_I;
            d_bsrc = 2'b01;
         end
         OPC_STORE: begin
            d_mem   = 1'b1;
            d_store = 1'b1;
            d_imm   = IMM_S;
            d_bsrc  = 2'b01;
         end
         OPC_BRANCH: begin
            d_branch = 1'b1;
            d_imm    = IMM_B;
            d_legal  = (funct3[2:1] != 2'b01);
            d_alu    = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
         end
         OPC_JAL: begin
            d_wreg = 1'b1;
            d_jal  = 1'b1;
            d_imm  = IMM_J;
            d_asrc = 1'b1;
            d_bsrc = 2'b10;
         end
         OPC_JALR: begin
            d_wreg = 1'b1;
            d_jalr = 1'b1;
            d_imm  = IMM_I;
            d_asrc = 1'b1;
            d_bsrc = 2'b10;
         end
         OPC_LUI: begin
            d_wreg = 1'b1;
            d_imm  = IMM_U;
            d_bsrc = 2'b01;
         end
         OPC_AUIPC: begin
            d_wreg = 1'b1;
            d_imm  = IMM_U;
            d_asrc = 1'b1;
            d_bsrc = 2'b01;
         end
         OPC_SYSTEM: d_imm = IMM_I;
         default:    d_legal = 1'b0;
      endcase
   end

   // Branch condition from the ALU flags seen during EXEC
   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         3'b000:          br_cond = is_zero;
         3'b001:          br_cond = !is_zero;
         3'b100, 3'b110:  br_cond = less;
         3'b101, 3'b111:  br_cond = !less;
         default:         br_cond = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Next-state logic; an ack arriving on the timeout cycle takes priority
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (imem_ack) state_d = S_DECODE;
                   else if (timed_out) state_d = S_ERR;
         S_DECODE: state_d = d_legal ? S_EXEC : S_ERR;
         S_EXEC:   state_d = d_mem ? S_MEM : S_WB;
         S_MEM:    if (dmem_ack) state_d = S_WB;
                   else if (timed_out) state_d = S_ERR;
         S_WB:     state_d = halt_after_wb ? S_HALT : S_FETCH;
         S_HALT:   state_d = S_HALT;
         S_ERR:    state_d = S_ERR;
         default:  state_d = S_ERR;
      endcase
   end

   // Handshake wait counter: restarts on every state change, counts unacked cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     wait_q <= '0;
      else if (state_d != state_q) wait_q <= '0;
      else if (waiting)            wait_q <= wait_q + 16'd1;
   end

   // Branch decision captured at the end of EXEC, used for pc_sel in WB
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    br_taken_q <= 1'b0;
      else if (state_q == S_EXEC) br_taken_q <= br_cond;
   end

   // Retired-instruction counter, bumped once per WB
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  instret_q <= '0;
      else if (state_q == S_WB) instret_q <= instret_q + INSTRET_W'(1);
   end

   // Strobes, requests and selects; everything forced low while rst is high
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      wreg_en  = 1'b0;
      pc_sel   = 2'b00;
      imm_sel  = IMM_NONE;
      alu_asrc = 1'b0;
      alu_bsrc = 2'b00;
      alu_sel  = ALU_ADD;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ack;
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = d_store;
            end
            S_WB: begin
               pc_we   = 1'b1;
               wreg_en = d_wreg;
               if (d_jalr)                             pc_sel = 2'b10;
               else if (d_jal || (d_branch && br_taken_q)) pc_sel = 2'b01;
            end
            default: ;
         endcase
         if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            imm_sel  = d_imm;
            alu_asrc = d_asrc;
            alu_bsrc = d_bsrc;
            alu_sel  = d_alu;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences against an ISA-level expectation model.
// Each cycle the driver publishes the expected outputs; one negedge process compares them.
// Honours EBREAK_HALT_EN for the ebreak expectation.
module tb_multicycle_ctrl;
   localparam int TO = 4;
   localparam int IW = 4;

   localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3,
                          ST_WB    = 3'd4, ST_HALT   = 3'd5, ST_ERR  = 3'd6;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   inst;
   logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, is_zero, less;
   logic          ir_we, pc_we, wreg_en, alu_asrc, halted, err;
   logic [1:0]    pc_sel, alu_bsrc;
   logic [2:0]    imm_sel, state;
   logic [3:0]    alu_sel;
   logic [IW-1:0] instret;

   multicycle_ctrl #(.TIMEOUT(TO), .INSTRET_W(IW)) dut (
      .clk(clk), .rst(rst), .inst(inst),
      .imem_req(imem_req), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .is_zero(is_zero), .less(less),
      .ir_we(ir_we), .pc_we(pc_we), .wreg_en(wreg_en), .pc_sel(pc_sel),
      .imm_sel(imm_sel), .alu_asrc(alu_asrc), .alu_bsrc(alu_bsrc), .alu_sel(alu_sel),
      .state(state), .halted(halted), .err(err), .instret(instret)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int m_ret = 0;

   logic       e_chk = 1'b0, e_sel_chk;
   logic [2:0] e_state, e_imm;
   logic       e_imem_req, e_dmem_req, e_dmem_we, e_ir_we, e_pc_we, e_wreg, e_asrc, e_err, e_halted;
   logic [1:0] e_pc_sel, e_bsrc;
   logic [3:0] e_alu;

   // What the ISA says an instruction needs from the control unit
   typedef struct packed {
      logic       legal, wreg, mem, store, br, jal, jalr, ebrk;
      logic [2:0] imm;
      logic       asrc;
      logic [1:0] bsrc;
      logic [3:0] alu;
   } ref_t;

   function automatic ref_t ref_decode(input logic [31:0] w);
      ref_t r;
      logic [2:0] f3;
      r = '0;
      f3 = w[14:12];
      r.legal = 1'b1;
      case (w[6:0])
         7'h33: begin r.wreg = 1; r.alu = {w[30], f3}; end
         7'h13: begin r.wreg = 1; r.imm = 3'd1; r.bsrc = 2'd1;
                      r.alu = (f3 == 3'b001 || f3 == 3'b101) ? {w[30], f3} : {1'b0, f3}; end
         7'h03: begin r.wreg = 1; r.mem = 1; r.imm = 3'd1; r.bsrc = 2'd1; end
         7'h23: begin r.mem = 1; r.store = 1; r.imm = 3'd2; r.bsrc = 2'd1; end
         7'h63: begin
            r.br = 1; r.imm = 3'd3;
            if (f3 == 3'b010 || f3 == 3'b011)      r.legal = 1'b0;
            else if (f3 == 3'b000 || f3 == 3'b001) r.alu = 4'b1000;  // SUB
            else if (f3 == 3'b100 || f3 == 3'b101) r.alu = 4'b0010;  // SLT
            else                                   r.alu = 4'b0011;  // SLTU
         end
         7'h6F: begin r.wreg = 1; r.jal = 1; r.imm = 3'd5; r.asrc = 1; r.bsrc = 2'd2; end
         7'h67: begin r.wreg = 1; r.jalr = 1; r.imm = 3'd1; r.asrc = 1; r.bsrc = 2'd2; end
         7'h37: begin r.wreg = 1; r.imm = 3'd4; r.bsrc = 2'd1; end
         7'h17: begin r.wreg = 1; r.imm = 3'd4; r.asrc = 1; r.bsrc = 2'd1; end
         7'h73: begin r.imm = 3'd1; r.ebrk = (f3 == 3'b000) && w[20]; end
         default: r.legal = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic l);
      case (f3)
         3'd0:       return z;
         3'd1:       return !z;
         3'd4, 3'd6: return l;
         3'd5, 3'd7: return !l;
         default:    return 1'b0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle(input logic [2:0] st);
      e_state = st; e_imem_req = 0; e_dmem_req = 0; e_dmem_we = 0; e_ir_we = 0;
      e_pc_we = 0; e_wreg = 0; e_pc_sel = 0; e_sel_chk = 0;
      e_err = (st == ST_ERR); e_halted = (st == ST_HALT);
   endtask

   task automatic set_sel(input ref_t r);
      e_sel_chk = r.legal; e_imm = r.imm; e_asrc = r.asrc; e_bsrc = r.bsrc; e_alu = r.alu;
   endtask

   task automatic do_reset();
      rst = 1; imem_ack = 0; dmem_ack = 0;
      set_idle(ST_FETCH);
      m_ret = 0;
      step(); step();
      rst = 0;
   endtask

   // ERR must absorb stray acks until reset
   task automatic enter_err();
      imem_ack = 1; dmem_ack = 1;
      set_idle(ST_ERR);
      repeat (3) step();
      do_reset();
   endtask

   // One instruction: iw/dw = wait cycles before ack (>= TO means never acked),
   // abort_mem >= 0 pulses rst after that many MEM cycles
   task automatic run_instr(input logic [31:0] w, input int iw, input int dw,
                            input logic z, input logic l, input int abort_mem);
      ref_t r;
      logic tk;
      r = ref_decode(w);
      for (int k = 0; k <= iw; k++) begin
         if (k == TO) begin enter_err(); return; end
         set_idle(ST_FETCH); e_imem_req = 1; e_ir_we = (k == iw);
         imem_ack = (k == iw); dmem_ack = 1;
         if (k == iw) inst = w;
         step();
      end
      imem_ack = 0; dmem_ack = 1;
      set_idle(ST_DECODE); set_sel(r);
      step();
      if (!r.legal) begin enter_err(); return; end
      dmem_ack = 0; is_zero = z; less = l;
      set_idle(ST_EXEC); set_sel(r);
      step();
      is_zero = !z; less = !l;
      if (r.mem) begin
         for (int k = 0; k <= dw; k++) begin
            if (abort_mem >= 0 && k == abort_mem) begin do_reset(); return; end
            if (k == TO) begin enter_err(); return; end
            set_idle(ST_MEM); set_sel(r); e_dmem_req = 1; e_dmem_we = r.store;
            dmem_ack = (k == dw); imem_ack = 1;
            step();
         end
      end
      tk = r.br && ref_taken(w[14:12], z, l);
      imem_ack = 0; dmem_ack = 1;
      set_idle(ST_WB); set_sel(r); e_pc_we = 1; e_wreg = r.wreg;
      e_pc_sel = r.jalr ? 2'd2 : ((r.jal || tk) ? 2'd1 : 2'd0);
      step();
      dmem_ack = 0;
      m_ret = m_ret + 1;
`ifdef EBREAK_HALT_EN
      if (r.ebrk) begin
         imem_ack = 1;
         set_idle(ST_HALT);
         repeat (3) step();
         do_reset();
      end
`endif
   endtask

   // Single compare point for every cycle the expectations are live
   always @(negedge clk) begin
      if (e_chk) begin
         chk("state",    32'(state),    32'(e_state));
         chk("imem_req", 32'(imem_req), 32'(e_imem_req));
         chk("dmem_req", 32'(dmem_req), 32'(e_dmem_req));
         chk("dmem_we",  32'(dmem_we),  32'(e_dmem_we));
         chk("ir_we",    32'(ir_we),    32'(e_ir_we));
         chk("pc_we",    32'(pc_we),    32'(e_pc_we));
         chk("wreg_en",  32'(wreg_en),  32'(e_wreg));
         chk("pc_sel",   32'(pc_sel),   32'(e_pc_sel));
         chk("err",      32'(err),      32'(e_err));
         chk("halted",   32'(halted),   32'(e_halted));
         chk("instret",  32'(instret),  32'(m_ret % 16));
         if (e_sel_chk) begin
            chk("imm_sel",  32'(imm_sel),  32'(e_imm));
            chk("alu_asrc", 32'(alu_asrc), 32'(e_asrc));
            chk("alu_bsrc", 32'(alu_bsrc), 32'(e_bsrc));
            chk("alu_sel",  32'(alu_sel),  32'(e_alu));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
      $fatal(1);
   end

   initial begin
      ref_t p;
      rst = 0; inst = 0; imem_ack = 0; dmem_ack = 0; is_zero = 0; less = 0;
      set_idle(ST_FETCH);
      e_imm = 0; e_asrc = 0; e_bsrc = 0; e_alu = 0;

      // Pin the model against hand-decoded encodings
      p = ref_decode(32'h00500093);
      chk("pin_addi_alu", 32'(p.alu), 32'h0);
      chk("pin_addi_wreg", 32'(p.wreg), 32'h1);
      p = ref_decode(32'h402081b3);
      chk("pin_sub_alu", 32'(p.alu), 32'h8);
      p = ref_decode(32'h000100E7);
      chk("pin_jalr_bsrc", 32'(p.bsrc), 32'h2);
      p = ref_decode(32'h0000007F);
      chk("pin_7f_illegal", 32'(p.legal), 32'h0);
      chk("pin_beq_taken", 32'(ref_taken(3'd0, 1'b1, 1'b0)), 32'h1);
      chk("pin_bgeu_taken", 32'(ref_taken(3'd7, 1'b0, 1'b1)), 32'h0);

      #2;
      e_chk = 1;
      do_reset();

      run_instr(32'h00500093, 3, 0, 0, 0, -1);                   // addi, ack on the timeout-boundary cycle
      chk("addi_instret", 32'(instret), 32'd1);
      for (int i = 0; i < 16; i++) run_instr(32'h00500093, 0, 0, 0, 0, -1);
      chk("wrap_instret", 32'(instret), 32'd1);                  // 17 retirements mod 16

      run_instr(32'h00000063, 1, 0, 1, 0, -1);                   // beq taken
      run_instr(32'h00000063, 0, 0, 0, 0, -1);                   // beq not taken
      run_instr(32'h00001063, 0, 0, 0, 1, -1);                   // bne taken
      run_instr(32'h00004063, 0, 0, 0, 1, -1);                   // blt taken
      run_instr(32'h00007063, 0, 0, 1, 1, -1);                   // bgeu not taken
      run_instr(32'h00006063, 0, 0, 1, 0, -1);                   // bltu not taken
      run_instr(32'h00002083, 0, 2, 0, 0, -1);                   // lw, 2 waits
      run_instr(32'h00102023, 2, 0, 0, 0, -1);                   // sw, immediate ack
      run_instr(32'h002081b3, 0, 0, 0, 0, -1);                   // add
      run_instr(32'h402081b3, 0, 0, 0, 0, -1);                   // sub
      run_instr(32'h4020d1b3, 0, 0, 0, 0, -1);                   // sra
      run_instr(32'h4030d093, 0, 0, 0, 0, -1);                   // srai
      run_instr(32'hC0000093, 0, 0, 0, 0, -1);                   // addi with imm[10] set stays ADD
      run_instr(32'h000000EF, 0, 0, 0, 0, -1);                   // jal
      run_instr(32'h000100E7, 0, 0, 0, 0, -1);                   // jalr
      run_instr(32'h000010B7, 0, 0, 0, 0, -1);                   // lui
      run_instr(32'h00001097, 0, 0, 0, 0, -1);                   // auipc
      run_instr(32'h00000073, 0, 0, 0, 0, -1);                   // ecall as NOP

      run_instr(32'h00002063, 0, 0, 0, 0, -1);                   // branch funct3=010 -> ERR
      run_instr(32'h0000007F, 0, 0, 0, 0, -1);                   // unknown opcode -> ERR
      run_instr(32'h00500093, 4, 0, 0, 0, -1);                   // fetch timeout -> ERR
      run_instr(32'h00002083, 0, 4, 0, 0, -1);                   // load timeout -> ERR
      run_instr(32'h00500093, 0, 0, 0, 0, -1);
      run_instr(32'h00002083, 0, 9, 0, 0, 1);                    // rst mid-MEM
      chk("rst_mem_instret", 32'(instret), 32'd0);
      run_instr(32'h00500093, 1, 0, 0, 0, -1);
      run_instr(32'h00100073, 0, 0, 0, 0, -1);                   // ebreak
      run_instr(32'h00500093, 0, 0, 0, 0, -1);

      e_chk = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
